// File: rtl/ddr_clock_monitor_pkg.sv
// Shared types for the differential clock monitor:
// FSM state encodings and fault code values.
package ddr_clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'b00,
        FC_COMP = 2'b01,
        FC_SLOW = 2'b10,
        FC_FAST = 2'b11
    } fault_code_e;

    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        if (v == {CNT_W{1'b1}}) return v;
        return v + CNT_W'(inc);
    endfunction

endpackage

// File: rtl/ddr_clock_monitor_sync_edge_detect.sv
// Two-flop synchroniser plus edge register for one clock leg.
// Rise pulses for one cycle when the synced level goes 0->1.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/ddr_clock_monitor.sv
// Frequency and complement checker for the ClockP/ClockN pair,
// with lock qualification and a sticky fault code.
module ddr_clock_monitor
    import ddr_clock_monitor_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned MIN_EDGES     = 100,
    parameter int unsigned MAX_EDGES     = 160,
    parameter int unsigned LOCK_WINDOWS  = 4,
    parameter int unsigned SKEW_MAX      = 2
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             ClockP,
    input  logic             ClockN,
    input  logic             Enable,
    input  logic             ClearFault,
    output logic [CNT_W-1:0] EdgeCount,
    output logic             CountValid,
    output logic             Locked,
    output logic             Fault,
    output logic [1:0]       FaultCode
);

    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int unsigned RUN_W  = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned SKEW_W = $clog2(SKEW_MAX + 2);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_WINDOWS);
    localparam logic [SKEW_W-1:0] SKEW_LIM = SKEW_W'(SKEW_MAX);
    localparam logic [SKEW_W-1:0] SKEW_TOP = SKEW_W'(SKEW_MAX + 1);

    logic sync_p, sync_n, rise_p, rise_n_unused;

    sync_edge_detect u_sync_p (
        .clk_i   (Clock),
        .rst_ni  (ResetN),
        .pin_i   (ClockP),
        .level_o (sync_p),
        .rise_o  (rise_p)
    );

    sync_edge_detect u_sync_n (
        .clk_i   (Clock),
        .rst_ni  (ResetN),
        .pin_i   (ClockN),
        .level_o (sync_n),
        .rise_o  (rise_n_unused)
    );

    state_e            state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [SKEW_W-1:0] skew_q, skew_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cv_q, cv_d;
    logic              lock_q, fault_q;
    fault_code_e       code_q, code_d;

    logic             active, tc, eq, comp_viol, in_range;
    logic [CNT_W-1:0] total;
    logic [RUN_W-1:0] run_inc;
    fault_code_e      range_code;

    assign active     = Enable && (state_q != ST_IDLE);
    assign tc         = active && (win_q == WIN_LAST);
    assign eq         = (sync_p == sync_n);
    assign comp_viol  = active && eq && (skew_q >= SKEW_LIM);
    // Edge seen on the terminal-count cycle still belongs to this window
    assign total      = sat_add(edge_q, rise_p);
    assign in_range   = (total >= CNT_W'(MIN_EDGES)) && (total <= CNT_W'(MAX_EDGES));
    assign range_code = (total < CNT_W'(MIN_EDGES)) ? FC_SLOW : FC_FAST;
    assign run_inc    = run_q + 1'b1;

    always_comb begin
        win_d  = '0;
        edge_d = '0;
        skew_d = '0;
        cnt_d  = cnt_q;
        cv_d   = 1'b0;
        if (active) begin
            win_d  = tc ? '0 : win_q + 1'b1;
            edge_d = tc ? '0 : total;
            if (eq) skew_d = (skew_q == SKEW_TOP) ? skew_q : skew_q + 1'b1;
            if (tc) begin
                cnt_d = total;
                cv_d  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        code_d  = code_q;
        if (!Enable) begin
            state_d = ST_IDLE;
            run_d   = '0;
            code_d  = FC_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    run_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (comp_viol) begin
                        state_d = ST_FAULT;
                        code_d  = FC_COMP;
                    end else if (tc) begin
                        if (!in_range) begin
                            run_d = '0;
                        end else if (run_inc == RUN_LOCK) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (comp_viol) begin
                        state_d = ST_FAULT;
                        code_d  = FC_COMP;
                    end else if (tc && !in_range) begin
                        state_d = ST_FAULT;
                        code_d  = range_code;
                    end
                end
                ST_FAULT: begin
                    // A live violation outranks the clear and re-arms the code
                    if (ClearFault) begin
                        if (comp_viol) begin
                            code_d = FC_COMP;
                        end else begin
                            state_d = ST_ACQUIRE;
                            run_d   = '0;
                            code_d  = FC_NONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            edge_q  <= '0;
            run_q   <= '0;
            skew_q  <= '0;
            cnt_q   <= '0;
            cv_q    <= 1'b0;
            lock_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            edge_q  <= edge_d;
            run_q   <= run_d;
            skew_q  <= skew_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            lock_q  <= (state_d == ST_LOCKED);
            fault_q <= (state_d == ST_FAULT);
            code_q  <= code_d;
        end
    end

    assign EdgeCount  = cnt_q;
    assign CountValid = cv_q;
    assign Locked     = lock_q;
    assign Fault      = fault_q;
    assign FaultCode  = code_q;

endmodule
